// File: rtl/multiplicador_seq.sv
// Sequential radix-2 shift-add multiplier: unsigned Q8.16 x Q8.16 -> Q16.16, start/done handshake.
// Optional round-half-up with saturation when MULT_ROUND_EN is defined; truncation otherwise.
module multiplicador_seq #(
    parameter int unsigned W_IN  = 24,
    parameter int unsigned FRAC  = 16,
    parameter int unsigned W_OUT = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W_IN-1:0]  in1,
    input  logic [W_IN-1:0]  in2,
    output logic [W_OUT-1:0] out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned W_ACC = 2 * W_IN;
    localparam int unsigned CW    = $clog2(W_IN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W_ACC-1:0]   mcand_q, mcand_d;
    logic [W_IN-1:0]    mplier_q, mplier_d;
    logic [W_ACC-1:0]   acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [W_OUT-1:0]   out_q, out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [W_OUT-1:0]   result;

`ifdef MULT_ROUND_EN
    logic [W_OUT:0] rnd_sum;

    // Carry out of the rounding add means the truncated value was all ones: saturate.
    always_comb begin
        rnd_sum = {1'b0, acc_q[W_ACC-1:FRAC]} + (W_OUT+1)'(acc_q[FRAC-1]);
        result  = rnd_sum[W_OUT] ? '1 : rnd_sum[W_OUT-1:0];
    end

    logic unused_frac;
    assign unused_frac = ^acc_q[FRAC-2:0];
`else
    assign result = acc_q[W_ACC-1:FRAC];

    logic unused_frac;
    assign unused_frac = ^acc_q[FRAC-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{(W_ACC-W_IN){1'b0}}, in1};
                    mplier_d = in2;
                    acc_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Multiplicand walks left, multiplier walks right: bit 0 always selects.
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(W_IN - 1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                out_d   = result;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_multiplicador_seq.sv
// Directed self-checking bench for multiplicador_seq; expected values hand-computed, both builds covered.
module tb_multiplicador_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [23:0] in1;
    logic [23:0] in2;
    logic [31:0] out_w;
    logic        busy_w;
    logic        done_w;

    int unsigned n_cmp;
    int unsigned n_err;

    multiplicador_seq #(
        .W_IN  (24),
        .FRAC  (16),
        .W_OUT (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .out   (out_w),
        .busy  (busy_w),
        .done  (done_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+#1; start is sampled at the next edge (edge k).
    task automatic start_op(input logic [23:0] a, input logic [23:0] b);
        in1   = a;
        in2   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", {31'd0, busy_w}, 32'd1);
        check("done_after_start", {31'd0, done_w}, 32'd0);
    endtask

    // Counts edges after edge k until done; bounded so a stuck DUT still ends.
    task automatic wait_done(input string tag, input logic [31:0] exp_out);
        int unsigned cyc;
        bit          busy_dropped;
        cyc = 0;
        busy_dropped = 1'b0;
        while (cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done_w) break;
            if (!busy_w) busy_dropped = 1'b1;
        end
        check({tag, "_latency"}, cyc, 32'd25);
        check({tag, "_busy_held"}, {31'd0, busy_dropped}, 32'd0);
        check({tag, "_busy_at_done"}, {31'd0, busy_w}, 32'd0);
        check({tag, "_out"}, out_w, exp_out);
    endtask

    initial begin
        logic [31:0] exp_typ;
        int unsigned done_cnt;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        in1   = '0;
        in2   = '0;
`ifdef MULT_ROUND_EN
        exp_typ = 32'h00823AC9;
`else
        exp_typ = 32'h00823AC8;
`endif

        repeat (3) @(posedge clk);
        #1;
        check("rst_out", out_w, 32'd0);
        check("rst_busy", {31'd0, busy_w}, 32'd0);
        check("rst_done", {31'd0, done_w}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("idle_state", {out_w[29:0], busy_w, done_w}, 32'd0);
        end

        start_op(24'h010000, 24'h010000);
        wait_done("unity", 32'h00010000);
        @(posedge clk);
        #1;
        check("unity_done_pulse", {31'd0, done_w}, 32'd0);
        check("unity_out_hold", out_w, 32'h00010000);

        start_op(24'h0B696D, 24'h0B696D);
        wait_done("typical", exp_typ);

        start_op(24'hFFFFFF, 24'hFFFFFF);
        wait_done("max", 32'hFFFFFE00);

        // Abort at cycle 10 of an operation; out previously non-zero.
        start_op(24'h0B696D, 24'h0B696D);
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_out", out_w, 32'd0);
        check("midrst_busy", {31'd0, busy_w}, 32'd0);
        check("midrst_done", {31'd0, done_w}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done_w) done_cnt++;
        end
        check("midrst_no_done", done_cnt, 32'd0);
        check("midrst_busy_idle", {31'd0, busy_w}, 32'd0);
        start_op(24'h0B696D, 24'h0B696D);
        wait_done("after_rst", exp_typ);

        // Zero multiplier, with a second start and operand change mid-run.
        start_op(24'h123456, 24'h000000);
        repeat (4) @(posedge clk);
        #1;
        in1   = 24'hFFFFFF;
        in2   = 24'hFFFFFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        in1   = 24'h0;
        begin
            int unsigned cyc;
            cyc = 5;
            while (cyc < 45) begin
                @(posedge clk);
                #1;
                cyc++;
                if (done_w) break;
            end
            check("hs_latency", cyc, 32'd25);
            check("hs_out_zero", out_w, 32'd0);
        end
        // Start on the cycle right after done.
        start_op(24'h020000, 24'h018000);
        wait_done("b2b", 32'h00030000);

        // The ignored second start must not have queued another operation.
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done_w || busy_w) done_cnt++;
        end
        check("hs_single_done", done_cnt, 32'd0);
        check("final_out_hold", out_w, 32'h00030000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multiplicador_seq.md
Name: multiplicador_seq

Overview:
- Sequential unsigned fixed-point multiplier for the datapath.
- Each input is a 24-bit Q8.16 operand (8 integer bits, 16 fraction bits).
- The full 48-bit Q16.32 product is reduced to a 32-bit Q16.16 result.
- Implemented as a radix-2 shift-add engine with a start/done handshake, trading latency for area.

Parameters:
- W_IN, 24, operand width (fixed; not exercised at other values)
- FRAC, 16, fraction bits per operand and in the result
- W_OUT, 32, result width (= 2*W_IN - FRAC)

Ports:
- clk  input  1  rising-edge clock, the block's only clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- in1  input  24  multiplicand, unsigned Q8.16
- in2  input  24  multiplier, unsigned Q8.16
- out  output  32  result, unsigned Q16.16, registered
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when out is updated

Behaviour:
- Reset (rst_n low, asynchronous):
  - out=0, busy=0, done=0.
  - Internal accumulator, operand registers and counter cleared.
  - State=IDLE.
- States: IDLE, RUN, FINISH.
- IDLE:
  - start=1 at rising edge k latches in1 and in2, clears the 48-bit accumulator and loads counter=0.
  - busy=1 from edge k. State goes to RUN.
- RUN, one iteration per cycle:
  - If multiplier bit[count]=1, add the multiplicand shifted left by count into the accumulator. Equivalently, shift the multiplicand left and the multiplier right each cycle.
  - Exactly 24 iterations, at edges k+1 .. k+24. The state then goes to FINISH.
- FINISH, at edge k+25:
  - out <= acc[47:16] (truncation toward zero).
  - done=1 for exactly this one cycle. busy=0. State goes to IDLE.
- Latency: 25 cycles from the start edge to the out/done edge.
- A new start is accepted on the cycle after done, so back-to-back throughput is 1 result per 26 cycles.
- start while busy: ignored. Operand changes while busy have no effect, because operands are latched.
- out holds its value between operations; it changes only at FINISH or reset.
- Arithmetic:
  - Fully unsigned.
  - The 48-bit accumulator cannot overflow, since max (2^24-1)^2 < 2^48.
  - Bits acc[15:0] are discarded unless MULT_ROUND_EN is defined.
- Zero operand: the operation still takes the full 25 cycles (no early termination) and yields out=0.
- Reset asserted mid-operation: the operation is aborted immediately, all outputs go to 0, and no done pulse is produced. After release the block is in IDLE.

Optional Feature:
- Macro MULT_ROUND_EN.
- When defined:
  - FINISH computes out = acc[47:16] + acc[15], i.e. round half up.
  - If acc[47:16]=32'hFFFFFFFF and acc[15]=1, out saturates at 32'hFFFFFFFF (no wrap).
  - Latency is unchanged (25 cycles).
- When not defined: plain truncation as described in Behaviour; no rounding logic is synthesized.

Test Plan:
- Reset then idle:
  - rst_n low, then high, no start -> out=0, busy=0, done=0 indefinitely.
- Unity:
  - in1=in2=24'h010000 (1.0), start one cycle.
  - -> busy for 25 cycles, done pulse at edge k+25, out=32'h00010000.
- Typical value:
  - in1=in2=24'h0B696D, start.
  - -> without the macro, out=32'h00823AC8.
  - -> with MULT_ROUND_EN, out=32'h00823AC9 (acc[15:0]=16'h9869).
- Max operands:
  - in1=in2=24'hFFFFFF.
  - -> out=32'hFFFFFE00 in both builds (acc[15]=0, no saturation).
- Handshake:
  - Start in2=0 with in1=24'h123456. Pulse start again and change the operands mid-run.
  - -> a single done, out=0, second start ignored.
  - A start on the cycle after done -> accepted, new result 25 cycles later.
- Reset mid-run:
  - Assert rst_n low at cycle 10 of an operation.
  - -> outputs 0 asynchronously, no done pulse.
  - A fresh start after release -> correct result.
